// File: rtl/sled_pkg.sv
// Shared font, off code and segment encoder for the seven-segment scan driver.
package sled_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low hex font, index = nibble value, bit7 = dp, bits6:0 = g..a.
  localparam logic [15:0][7:0] HEX_FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Active-low segment byte for one digit; blank overrides the dp.
  function automatic logic [7:0] to_seg(input logic [3:0] nibble,
                                        input logic       dp,
                                        input logic       blank);
    logic [7:0] s;
    s = HEX_FONT[nibble];
    if (dp) s[7] = 1'b0;
    if (blank) s = SEG_OFF;
    return s;
  endfunction

endpackage

// File: rtl/sled_prescale.sv
// Slot prescaler: registered terminal-count pulse and anti-ghosting blank window.
module sled_prescale #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic clock,
  input  logic reset,
  output logic tc,
  output logic in_blank
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          blank_next;

  // Next count value; flags are registered against it so they line up with count.
  always_comb begin
    count_next = count + CW'(1);
    if (count == LAST) count_next = '0;
  end

  if (BLANK_CYC == 0) begin : g_no_blank
    assign blank_next = 1'b0;
  end else begin : g_blank
    assign blank_next = (count_next < CW'(BLANK_CYC));
  end

  // Count register with tc (count == LAST) and in_blank (count < BLANK_CYC).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      tc       <= 1'b0;
      in_blank <= (BLANK_CYC != 0);
    end else begin
      count    <= count_next;
      tc       <= (count_next == LAST);
      in_blank <= blank_next;
    end
  end

endmodule

// File: rtl/sled_scan.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous double buffer.
module sled_scan
  import sled_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYC      = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_tick
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_IDLE = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW ? '1 : '0;

  logic                  tc;
  logic                  in_blank;
  logic                  wrap_c;
  logic [IW-1:0]         idx;

  logic [DW-1:0]         shadow_data;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [NUM_DIGITS-1:0] shadow_blank;
  logic                  pending;
  logic [DW-1:0]         active_data;
  logic [NUM_DIGITS-1:0] active_dp;
  logic [NUM_DIGITS-1:0] active_blank;

  logic [3:0]            nibble_c;
  logic [7:0]            seg_c;
  logic [NUM_DIGITS-1:0] dig_c;

  sled_prescale #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_prescale (
    .clock    (clock),
    .reset    (reset),
    .tc       (tc),
    .in_blank (in_blank)
  );

  assign wrap_c = tc && (idx == IDX_LAST);

  // Digit index advances once per slot and wraps into a new frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap_c;
      if (tc) idx <= wrap_c ? '0 : idx + IW'(1);
    end
  end

  // Double buffer: loads land in shadow; active only changes on a frame wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      pending      <= 1'b0;
      active_data  <= '0;
      active_dp    <= '0;
      active_blank <= '0;
    end else begin
      if (load) begin
        shadow_data  <= data_in;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
      end
      if (wrap_c) begin
        pending <= 1'b0;
        if (load) begin
          active_data  <= data_in;
          active_dp    <= dp_in;
          active_blank <= blank_in;
        end else if (pending) begin
          active_data  <= shadow_data;
          active_dp    <= shadow_dp;
          active_blank <= shadow_blank;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Decode the selected digit in active-low, active-high select form.
  always_comb begin
    nibble_c = 4'(active_data >> {idx, 2'b00});
    seg_c    = to_seg(nibble_c, active_dp[idx], active_blank[idx]);
    dig_c    = NUM_DIGITS'(1) << idx;
    if (in_blank) begin
      seg_c = SEG_OFF;
      dig_c = '0;
    end
  end

  // Output registers apply board polarity.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg <= SEG_IDLE;
      dig <= DIG_IDLE;
    end else begin
      seg <= SEG_ACTIVE_LOW ? seg_c : ~seg_c;
      dig <= DIG_ACTIVE_LOW ? ~dig_c : dig_c;
    end
  end

endmodule

// File: tb/tb_sled_scan.sv
// Scoreboard bench for sled_scan: time-indexed reference model feeds a queue,
// a negedge monitor pops and compares seg/dig/frame_tick every cycle.
module tb_sled_scan;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int F  = N * SD;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } word_t;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       ft;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load  = 1'b0;
  logic [15:0] data_in  = '0;
  logic [3:0]  dp_in    = '0;
  logic [3:0]  blank_in = '0;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t  q[$];
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // reference model state: t = cycles since reset release
  int    t = 0;
  bit    started = 0;
  word_t m_shadow, m_active, prev_word;
  bit    m_pend = 0;
  int    prev_pos, prev_dig;

  sled_scan #(
    .NUM_DIGITS     (N),
    .SCAN_DIV       (SD),
    .BLANK_CYC      (BC),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .seg        (seg),
    .dig        (dig),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d, time %0t)", name, act, req, t, $time);
    end
  endtask

  // What the display should show for a given slot position, digit and word.
  function automatic exp_t expect_for(int pos, int d, word_t w);
    exp_t e;
    logic [3:0] nib;
    e.ft = 1'b0;
    if (pos < BC) begin
      e.seg = 8'hFF;
      e.dig = 4'hF;
    end else begin
      e.dig = ~(4'b0001 << d);
      nib   = w.data[d*4 +: 4];
      if (w.blank[d]) e.seg = 8'hFF;
      else            e.seg = font[nib] & (w.dp[d] ? 8'h7F : 8'hFF);
    end
    return e;
  endfunction

  // One clock cycle of stimulus; pushes the expected outputs for that cycle.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    exp_t e;
    if (started) begin
      @(posedge clock);
      #1;
    end
    started = 1;
    if (t == 0) e = '{seg: 8'hFF, dig: 4'hF, ft: 1'b0};
    else begin
      e    = expect_for(prev_pos, prev_dig, prev_word);
      e.ft = (t % F == 0);
    end
    q.push_back(e);
    load = ld; data_in = d; dp_in = p; blank_in = b;
    prev_pos  = t % SD;
    prev_dig  = (t / SD) % N;
    prev_word = m_active;
    if (ld) begin
      m_shadow = '{data: d, dp: p, blank: b};
      m_pend   = 1;
    end
    if ((t + 1) % F == 0 && m_pend) begin
      m_active = m_shadow;
      m_pend   = 0;
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  // Assert reset asynchronously mid-cycle, check outputs go off at once, then release.
  task automatic do_reset(input string tag);
    @(posedge clock);
    #1;
    reset = 1'b1;
    load  = 1'b0;
    #1;
    check({tag, "_seg_async"}, 32'(seg), 32'hFF);
    check({tag, "_dig_async"}, 32'(dig), 32'hF);
    check({tag, "_ft_async"}, 32'(frame_tick), 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check({tag, "_seg_hold"}, 32'(seg), 32'hFF);
      check({tag, "_dig_hold"}, 32'(dig), 32'hF);
    end
    @(posedge clock);
    #1;
    reset    = 1'b0;
    t        = 0;
    started  = 0;
    m_shadow = '0;
    m_active = '0;
    m_pend   = 0;
  endtask

  // Monitor: compares every presented output cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("seg", 32'(seg), 32'(e.seg));
        check("dig", 32'(dig), 32'(e.dig));
        check("frame_tick", 32'(frame_tick), 32'(e.ft));
      end
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    m_shadow = '0;
    m_active = '0;
    prev_word = '0;
    prev_pos = 0;
    prev_dig = 0;
    repeat (2) @(posedge clock);
    do_reset("por");

    // idle scan of zeros across two frames
    idle(2 * F + 3);

    // mid-frame load held back until the next frame
    step(1'b1, 16'h3A91, 4'h0, 4'h0);
    idle(2 * F);

    // load on the exact wrap cycle goes live with no frame of delay
    while ((t + 1) % F != 0) step(1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b1, 16'h5555, 4'h0, 4'h0);
    idle(F + 2);

    // dp and blank handling
    step(1'b1, 16'h8888, 4'b0010, 4'b1000);
    idle(2 * F);

    // two loads in one frame: last write wins
    while (t % F != 3) step(1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b1, 16'h1111, 4'h0, 4'h0);
    idle(4);
    step(1'b1, 16'h2222, 4'h0, 4'h0);
    idle(2 * F);

    // randomized loads, including some landing on wrap cycles
    for (int i = 0; i < 400; i++) begin
      logic ld;
      ld = ($urandom_range(0, 5) == 0) || (((t + 1) % F == 0) && ($urandom_range(0, 1) == 0));
      step(ld, 16'($urandom), 4'($urandom), 4'($urandom & $urandom));
    end

    // pending load then reset during slot 2: pending lost, scan restarts at digit 0
    while ((t / SD) % N != 1) step(1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b1, 16'hBEEF, 4'hF, 4'h0);
    while ((t / SD) % N != 2 || t % SD != 2) step(1'b0, 16'h0, 4'h0, 4'h0);
    do_reset("mid");
    idle(2 * F + 2);

    @(negedge clock);
    #1;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
